bus_fifo_reader: RTL and testbench

- Read-side buffer for the 4-bit flip-flop register bus.
- Captures words presented on the bus write strobe into an 8-deep circular store.
- Delivers them in order to a downstream consumer over a valid/ready handshake, with true and complemented data outputs (q/qbar style).
- Sits between a flip-flop bus producer and any slower reader in the memory subsystem.

---
 rtl/bus_fifo_reader.sv | 88 ++++++++
 tb/tb_bus_fifo_reader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bus_fifo_reader.sv
// Read-side buffer for the flip-flop register bus: an 8-deep circular store
// with first-word-fall-through delivery over valid/ready and q/qbar data outputs.
module bus_fifo_reader #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] rd_data_bar,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [AW:0]   count_reg, count_next;
   logic          overflow_reg, overflow_next;
   logic          push, pop;
   logic [WIDTH-1:0] head_word;

   // Status is derived from the occupancy count, never from pointer equality.
   assign full     = (count_reg == (AW+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   assign rd_valid = ~empty;
   assign count    = count_reg;
   assign overflow = overflow_reg;

   assign pop  = rd_ready & rd_valid;
   assign push = wr_en & (~full | pop);

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      if (flush) begin
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         overflow_next = 1'b0;
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
         count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);
         if (wr_en && !push) overflow_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage is deliberately left out of reset; outputs are masked until valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_reg] <= wr_data;
   end

   assign head_word = mem[rd_ptr_reg];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
         assign rd_data[gi]     = rd_valid & head_word[gi];
         assign rd_data_bar[gi] = ~rd_data[gi];
      end
   endgenerate

endmodule

// File: tb/tb_bus_fifo_reader.sv
// Directed bench for bus_fifo_reader: a queue holds the words expected at the
// read port, pushed when a write is accepted and popped as words are consumed.
module tb_bus_fifo_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       wr_en;
   logic [3:0] wr_data;
   logic       rd_ready;
   logic       rd_valid;
   logic [3:0] rd_data;
   logic [3:0] rd_data_bar;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   logic [3:0] sb[$];
   bit ov_model = 1'b0;

   always #5 clk = ~clk;

   bus_fifo_reader #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_data_bar(rd_data_bar), .full(full), .empty(empty), .count(count),
      .overflow(overflow)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_status();
      check("count",    {4'h0, count},   8'(sb.size()));
      check("empty",    {7'h0, empty},   {7'h0, sb.size() == 0});
      check("full",     {7'h0, full},    {7'h0, sb.size() == 8});
      check("overflow", {7'h0, overflow}, {7'h0, ov_model});
   endtask

   // One bus cycle: drive just after a falling edge, check the head word
   // before the rising edge, update the model, then check status afterwards.
   task automatic cycle(input bit w, input logic [3:0] d, input bit r);
      bit was_full;
      bit pop_now;
      logic [3:0] head;
      flush = 1'b0; wr_en = w; wr_data = d; rd_ready = r;
      #1;
      was_full = (sb.size() == 8);
      head     = (sb.size() > 0) ? sb[0] : 4'h0;
      check("rd_valid",    {7'h0, rd_valid}, {7'h0, sb.size() > 0});
      check("rd_data",     {4'h0, rd_data},  {4'h0, head});
      check("rd_data_bar", {4'h0, rd_data_bar}, {4'h0, ~head});
      pop_now = r && (sb.size() > 0);
      if (pop_now) void'(sb.pop_front());
      if (w && (!was_full || pop_now)) sb.push_back(d);
      else if (w) ov_model = 1'b1;
      @(negedge clk);
      check_status();
      $display("txn wr=%0d data=%h rd=%0d -> count=%0d rd_data=%h ovf=%0d",
               w, d, r, count, rd_data, overflow);
   endtask

   initial begin
      logic [3:0] seq1 [8];
      logic [3:0] seq2 [3];
      seq1 = '{4'h0, 4'h3, 4'h7, 4'hE, 4'hA, 4'h1, 4'h2, 4'h5};
      seq2 = '{4'h9, 4'hB, 4'hC};

      reset = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 4'h0; rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_status();
      check("reset rd_data",     {4'h0, rd_data},     8'h00);
      check("reset rd_data_bar", {4'h0, rd_data_bar}, 8'h0F);
      check("reset rd_valid",    {7'h0, rd_valid},    8'h00);

      // Single word
      cycle(1'b1, 4'h3, 1'b0);
      check("single data", {4'h0, rd_data}, 8'h03);
      check("single bar",  {4'h0, rd_data_bar}, 8'h0C);
      cycle(1'b0, 4'h0, 1'b1);

      // Order and wrap
      foreach (seq1[i]) cycle(1'b1, seq1[i], 1'b0);
      check("fill full", {7'h0, full}, 8'h01);
      repeat (3) cycle(1'b0, 4'h0, 1'b1);
      foreach (seq2[i]) cycle(1'b1, seq2[i], 1'b0);
      repeat (8) cycle(1'b0, 4'h0, 1'b1);
      check("drained empty", {7'h0, empty}, 8'h01);

      // Overflow, then simultaneous push/pop while full
      for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 1), 1'b0);
      cycle(1'b1, 4'hF, 1'b0);
      check("ovf set", {7'h0, overflow}, 8'h01);
      cycle(1'b1, 4'h6, 1'b1);
      check("full simult count", {4'h0, count}, 8'h08);
      repeat (8) cycle(1'b0, 4'h0, 1'b1);
      repeat (3) cycle(1'b1, 4'h8, 1'b0);
      flush = 1'b1; wr_en = 1'b1; wr_data = 4'h1; rd_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; wr_en = 1'b0; rd_ready = 1'b0;
      sb.delete(); ov_model = 1'b0;
      check_status();
      $display("txn flush -> count=%0d ovf=%0d", count, overflow);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 10), 1'b0);
      #2 reset = 1'b0;
      #1;
      sb.delete(); ov_model = 1'b0;
      check("async empty",    {7'h0, empty},    8'h01);
      check("async rd_valid", {7'h0, rd_valid}, 8'h00);
      check("async count",    {4'h0, count},    8'h00);
      $display("txn async reset -> empty=%0d rd_valid=%0d", empty, rd_valid);
      @(negedge clk);
      reset = 1'b1;
      cycle(1'b1, 4'hD, 1'b0);
      check("post reset data", {4'h0, rd_data}, 8'h0D);
      cycle(1'b0, 4'h0, 1'b1);

      // Empty with simultaneous write and read
      cycle(1'b1, 4'h4, 1'b1);
      check("empty simult count", {4'h0, count}, 8'h01);
      cycle(1'b0, 4'h0, 1'b0);
      check("empty simult data", {4'h0, rd_data}, 8'h04);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
